cpu_step_controller: RTL and testbench

//  Consumes the divided clock from Clock_divider and produces a one-cycle CPU clock-enable.
//  The RV32I core runs on clock_in and advances only when cpu_en=1; no derived clock nets.

---
 rtl/cpu_step_controller_pkg.sv | 14 +
 rtl/cpu_step_controller_if.sv | 24 ++
 rtl/cpu_step_controller_button_debouncer.sv | 46 ++++
 rtl/cpu_step_controller.sv | 104 ++++++++++
 tb/tb_cpu_step_controller.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_step_controller_pkg.sv
// Shared types and constants for the CPU step controller slice.
package step_ctrl_pkg;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned COUNT_W     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } state_t;

endpackage

// File: rtl/cpu_step_controller_if.sv
// Board/core side signals of the step controller; slave is the controller view.
interface cpu_step_controller_if;
    import step_ctrl_pkg::*;

    logic               slow_clock;
    logic               mode_run;
    logic               step_btn;
    logic               halt_req;
    logic               cpu_en;
    logic               running;
    logic               halted;
    logic [COUNT_W-1:0] step_count;

    modport master (
        output slow_clock, mode_run, step_btn, halt_req,
        input  cpu_en, running, halted, step_count
    );

    modport slave (
        input  slow_clock, mode_run, step_btn, halt_req,
        output cpu_en, running, halted, step_count
    );

endinterface

// File: rtl/cpu_step_controller_button_debouncer.sv
// Synchronises a bouncy pushbutton, filters it by a stability counter and
// reports a one-cycle pulse when the filtered level rises.
module button_debouncer
    import step_ctrl_pkg::*;
#(
    parameter int unsigned     DB_W            = 28,
    parameter logic [DB_W-1:0] DEBOUNCE_CYCLES = DB_W'(1_000_000)
) (
    input  logic clock_in,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    logic [SYNC_STAGES-1:0] btn_sync;
    logic [DB_W-1:0]        db_cnt;
    logic                   btn_s;

    assign btn_s = btn_sync[SYNC_STAGES-1];

    // Level only follows the synced input after DEBOUNCE_CYCLES consecutive disagreements.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            btn_sync  <= '0;
            db_cnt    <= '0;
            btn_level <= 1'b0;
            btn_press <= 1'b0;
        end else begin
            btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn_raw};
            btn_press <= 1'b0;
            if (btn_s != btn_level) begin
                if (db_cnt == DEBOUNCE_CYCLES - DB_W'(1)) begin
                    btn_level <= btn_s;
                    btn_press <= btn_s;
                    db_cnt    <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/cpu_step_controller.sv
// Turns the divided clock into a one-cycle core enable, gated by run/step/halt
// control, and counts issued enables.
module cpu_step_controller
    import step_ctrl_pkg::*;
#(
    parameter int unsigned     DB_W            = 28,
    parameter logic [DB_W-1:0] DEBOUNCE_CYCLES = DB_W'(1_000_000)
) (
    input  logic                  clock_in,
    input  logic                  reset_n,
    cpu_step_controller_if.slave  bus
);

    logic [SYNC_STAGES:0]   slow_sync;
    logic [SYNC_STAGES-1:0] mode_sync;
    logic                   tick;
    logic                   mode_s;
    logic                   press;
    logic                   btn_level_unused;

    state_t             state_q;
    state_t             next_state;
    logic               permit;
    logic               cpu_en_d;
    logic               cpu_en_q;
    logic               running_q;
    logic               halted_q;
    logic [COUNT_W-1:0] step_count_q;

    button_debouncer #(
        .DB_W            (DB_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .btn_raw   (bus.step_btn),
        .btn_level (btn_level_unused),
        .btn_press (press)
    );

    // slow_clock is sampled as data; its extra stage gives a rising-edge tick.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            slow_sync <= '0;
            mode_sync <= '0;
        end else begin
            slow_sync <= {slow_sync[SYNC_STAGES-1:0], bus.slow_clock};
            mode_sync <= {mode_sync[SYNC_STAGES-2:0], bus.mode_run};
        end
    end

    assign tick   = slow_sync[SYNC_STAGES-1] & ~slow_sync[SYNC_STAGES];
    assign mode_s = mode_sync[SYNC_STAGES-1];

    always_comb begin
        next_state = state_q;
        permit     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.halt_req)  next_state = HALT;
                else if (mode_s)   next_state = RUN;
                else if (press)    next_state = STEP;
            end
            RUN: begin
                permit = !bus.halt_req;
                if (bus.halt_req)  next_state = HALT;
                else if (!mode_s)  next_state = IDLE;
            end
            STEP: begin
                permit = !bus.halt_req;
                if (bus.halt_req)  next_state = HALT;
                else if (tick)     next_state = IDLE;
            end
            HALT: begin
                if (press && !bus.halt_req) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        cpu_en_d = tick & permit;
    end

    // Status flags track next_state so they change on the same edge as state_q.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cpu_en_q     <= 1'b0;
            running_q    <= 1'b0;
            halted_q     <= 1'b0;
            step_count_q <= '0;
        end else begin
            state_q      <= next_state;
            cpu_en_q     <= cpu_en_d;
            running_q    <= (next_state == RUN);
            halted_q     <= (next_state == HALT);
            step_count_q <= step_count_q + COUNT_W'(cpu_en_d);
        end
    end

    assign bus.cpu_en     = cpu_en_q;
    assign bus.running    = running_q;
    assign bus.halted     = halted_q;
    assign bus.step_count = step_count_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller: run, step, glitch, halt, wrap, reset.
module tb_cpu_step_controller;
    import step_ctrl_pkg::*;

    logic clock_in = 1'b0;
    logic reset_n  = 1'b0;
    always #5 clock_in = ~clock_in;

    cpu_step_controller_if bus();

    cpu_step_controller #(
        .DB_W            (28),
        .DEBOUNCE_CYCLES (28'd4)
    ) dut (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .bus      (bus.slave)
    );

    int   total    = 0;
    int   bad      = 0;
    int   cyc_n    = 0;
    int   rise_cyc = -100;
    int   pulses   = 0;
    int   presses  = 0;
    int   phase    = 0;
    bit   slow_en  = 1'b0;
    logic prev_en  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample just after the edge, monitor pulses, then advance the slow clock.
    task automatic cyc();
        @(posedge clock_in);
        #1;
        cyc_n++;
        if (bus.cpu_en === 1'b1) begin
            pulses++;
            chk("en_width", 64'(prev_en), 64'd0);
            if (slow_en) chk("en_latency", 64'(cyc_n - rise_cyc), 64'd3);
        end
        prev_en = bus.cpu_en;
        if (dut.u_db.btn_press === 1'b1) presses++;
        if (slow_en) begin
            if (phase == 0) rise_cyc = cyc_n;
            bus.slow_clock = (phase < 10);
            phase = (phase + 1) % 20;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) cyc();
    endtask

    task automatic slow_periods(input int n);
        phase   = 0;
        slow_en = 1'b1;
        repeat (n * 20) cyc();
        slow_en        = 1'b0;
        bus.slow_clock = 1'b0;
        cycles(6);
    endtask

    task automatic press_clean();
        bus.step_btn = 1'b1;
        cycles(8);
        bus.step_btn = 1'b0;
        cycles(8);
    endtask

    initial begin
        bus.slow_clock = 1'b0;
        bus.mode_run   = 1'b0;
        bus.step_btn   = 1'b0;
        bus.halt_req   = 1'b0;

        // Reset state
        cycles(3);
        chk("rst_cpu_en",  64'(bus.cpu_en),     64'd0);
        chk("rst_running", 64'(bus.running),    64'd0);
        chk("rst_halted",  64'(bus.halted),     64'd0);
        chk("rst_count",   64'(bus.step_count), 64'd0);
        reset_n = 1'b1;
        cycles(2);

        // Free-run: ten slow periods, ten enables
        bus.mode_run = 1'b1;
        cycles(5);
        chk("run_running", 64'(bus.running), 64'd1);
        pulses = 0;
        slow_periods(10);
        chk("run_pulses",  64'(pulses),         64'd10);
        chk("run_count",   64'(bus.step_count), 64'd10);
        chk("run_running2",64'(bus.running),    64'd1);
        chk("run_halted",  64'(bus.halted),     64'd0);

        // Single step with a bouncy press
        bus.mode_run = 1'b0;
        cycles(5);
        chk("idle_running", 64'(bus.running), 64'd0);
        presses = 0;
        pulses  = 0;
        bus.step_btn = 1'b0; cyc();
        bus.step_btn = 1'b1; cyc();
        bus.step_btn = 1'b0; cyc();
        bus.step_btn = 1'b1; cycles(11);
        bus.step_btn = 1'b0; cycles(8);
        chk("step_presses", 64'(presses),       64'd1);
        chk("step_state",   64'(dut.state_q),   64'(STEP));
        chk("step_nopulse", 64'(pulses),        64'd0);
        slow_periods(1);
        chk("step_pulses",  64'(pulses),         64'd1);
        chk("step_idle",    64'(dut.state_q),    64'(IDLE));
        chk("step_count",   64'(bus.step_count), 64'd11);

        // Short glitch is filtered
        presses = 0;
        pulses  = 0;
        bus.step_btn = 1'b1; cycles(3);
        bus.step_btn = 1'b0; cycles(8);
        chk("glitch_presses", 64'(presses),         64'd0);
        chk("glitch_dbcnt",   64'(dut.u_db.db_cnt), 64'd0);
        chk("glitch_state",   64'(dut.state_q),     64'(IDLE));
        slow_periods(1);
        chk("glitch_pulses",  64'(pulses),          64'd0);
        chk("glitch_count",   64'(bus.step_count),  64'd11);

        // Halt coincident with a tick
        bus.mode_run = 1'b1;
        cycles(5);
        chk("halt_pre_run", 64'(bus.running), 64'd1);
        pulses = 0;
        bus.slow_clock = 1'b1;
        cycles(2);
        chk("halt_tick",    64'(dut.tick), 64'd1);
        bus.halt_req = 1'b1;
        cyc();
        chk("halt_cpu_en",  64'(bus.cpu_en),  64'd0);
        chk("halt_halted",  64'(bus.halted),  64'd1);
        chk("halt_running", 64'(bus.running), 64'd0);
        bus.slow_clock = 1'b0;
        cycles(4);
        slow_periods(2);
        chk("halt_hold_pulses", 64'(pulses),     64'd0);
        chk("halt_hold_halted", 64'(bus.halted), 64'd1);
        bus.halt_req = 1'b0;
        slow_periods(1);
        chk("halt_rel_pulses",  64'(pulses),     64'd0);
        chk("halt_rel_halted",  64'(bus.halted), 64'd1);
        bus.mode_run = 1'b0;
        cycles(4);
        press_clean();
        chk("halt_exit_halted", 64'(bus.halted),     64'd0);
        chk("halt_exit_state",  64'(dut.state_q),    64'(IDLE));
        chk("halt_exit_count",  64'(bus.step_count), 64'd11);

        // Counter wrap
        bus.mode_run = 1'b1;
        cycles(5);
        force dut.step_count_q = 32'hFFFF_FFFF;
        cyc();
        release dut.step_count_q;
        cyc();
        chk("wrap_preset", 64'(bus.step_count), 64'hFFFF_FFFF);
        pulses = 0;
        slow_periods(1);
        chk("wrap_pulses",  64'(pulses),         64'd1);
        chk("wrap_count",   64'(bus.step_count), 64'd0);
        chk("wrap_running", 64'(bus.running),    64'd1);
        chk("wrap_halted",  64'(bus.halted),     64'd0);

        // Reset during an enable pulse
        bus.slow_clock = 1'b1;
        cycles(3);
        chk("mid_cpu_en_hi", 64'(bus.cpu_en), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_cpu_en_lo", 64'(bus.cpu_en),     64'd0);
        chk("mid_running",   64'(bus.running),    64'd0);
        chk("mid_halted",    64'(bus.halted),     64'd0);
        chk("mid_count",     64'(bus.step_count), 64'd0);
        chk("mid_state",     64'(dut.state_q),    64'(IDLE));
        bus.slow_clock = 1'b0;
        cycles(2);
        reset_n = 1'b1;
        pulses = 0;
        cycles(6);
        chk("post_rst_pulses",  64'(pulses),      64'd0);
        chk("post_rst_running", 64'(bus.running), 64'd1);
        slow_periods(1);
        chk("post_rst_first",   64'(pulses),         64'd1);
        chk("post_rst_count",   64'(bus.step_count), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
